// File: rtl/avst_pkt_fifo.sv
// avst_pkt_fifo: store-and-forward Avalon-ST packet FIFO.
// Beats are buffered until the packet's endofpacket beat arrives, then the
// whole packet becomes visible on the source port. Malformed packets (a new
// sop before eop) and packets too large for the buffer are discarded whole.
module avst_pkt_fifo #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int ERR_W   = 1,
  parameter int DEPTH   = 64
) (
  input  logic                     clk,
  input  logic                     reset,

  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [EMPTY_W-1:0]       in_empty,
  input  logic [ERR_W-1:0]         in_error,

  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [EMPTY_W-1:0]       out_empty,
  output logic [ERR_W-1:0]         out_error,

  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Beat storage, one entry per accepted beat
  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic               mem_sop   [DEPTH];
  logic               mem_eop   [DEPTH];
  logic [EMPTY_W-1:0] mem_empty [DEPTH];
  logic [ERR_W-1:0]   mem_error [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    state;

  logic [PW-1:0] used;
  logic          full;
  logic          in_xfer;
  logic          out_xfer;
  logic          pkt_dec;

  logic          take_beat;
  logic          rewind;
  logic [PW-1:0] beat_base;
  logic [PW-1:0] beat_next;
  logic          fills_buffer;
  logic          overflow;

  logic          wr_en;
  logic          commit_evt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] commit_nxt;
  logic [1:0]    state_nxt;
  logic          drop_nxt;

  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == DEPTH_P);
  assign in_ready  = !full || (state == ST_DROP);
  assign out_valid = (rd_ptr != commit_ptr);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign pkt_dec   = out_xfer && out_endofpacket;

  assign out_data          = mem_data[rd_ptr[AW-1:0]];
  assign out_startofpacket = mem_sop[rd_ptr[AW-1:0]];
  assign out_endofpacket   = mem_eop[rd_ptr[AW-1:0]];
  assign out_empty         = mem_empty[rd_ptr[AW-1:0]];
  assign out_error         = mem_error[rd_ptr[AW-1:0]];

  // Classify the incoming beat: where it lands and whether it overflows.
  // Overflow is caught on the beat that would fill the buffer while no
  // complete packet is held, so drop lands one cycle after that beat.
  always_comb begin
    take_beat = 1'b0;
    rewind    = 1'b0;
    beat_base = wr_ptr;
    if (in_xfer) begin
      if (state == ST_IDLE && in_startofpacket) begin
        take_beat = 1'b1;
      end else if (state == ST_PKT) begin
        take_beat = 1'b1;
        if (in_startofpacket) begin
          rewind    = 1'b1;
          beat_base = commit_ptr;
        end
      end
    end
    beat_next    = beat_base + ONE_P;
    fills_buffer = ((beat_next - rd_ptr) == DEPTH_P);
    overflow     = take_beat && !in_endofpacket && fills_buffer && (pkt_count == '0);
  end

  // Write-side next state: pointer moves, commits and drop requests
  always_comb begin
    wr_en      = take_beat && !overflow;
    commit_evt = 1'b0;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    state_nxt  = state;
    drop_nxt   = 1'b0;
    if (overflow) begin
      wr_ptr_nxt = commit_ptr;
      state_nxt  = ST_DROP;
      drop_nxt   = 1'b1;
    end else if (take_beat) begin
      wr_ptr_nxt = beat_next;
      drop_nxt   = rewind;
      if (in_endofpacket) begin
        commit_nxt = beat_next;
        commit_evt = 1'b1;
        state_nxt  = ST_IDLE;
      end else begin
        state_nxt  = ST_PKT;
      end
    end else if (in_xfer && state == ST_DROP && in_endofpacket) begin
      state_nxt = ST_IDLE;
    end
    if (state != ST_IDLE && state != ST_PKT && state != ST_DROP) begin
      state_nxt = ST_IDLE;
    end
  end

  // Store accepted beats; storage needs no reset since pointers guard it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[beat_base[AW-1:0]]  <= in_data;
      mem_sop[beat_base[AW-1:0]]   <= in_startofpacket;
      mem_eop[beat_base[AW-1:0]]   <= in_endofpacket;
      mem_empty[beat_base[AW-1:0]] <= in_empty;
      mem_error[beat_base[AW-1:0]] <= in_error;
    end
  end

  // Write pointer, commit pointer, FSM state and the drop pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      state      <= ST_IDLE;
      drop       <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      state      <= state_nxt;
      drop       <= drop_nxt;
    end
  end

  // Read pointer advances on every output transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (out_xfer) begin
      rd_ptr <= rd_ptr + ONE_P;
    end
  end

  // Complete-packet count: up on commit, down when an eop beat leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
    end else begin
      case ({commit_evt, pkt_dec})
        2'b10:   pkt_count <= pkt_count + ONE_P;
        2'b01:   pkt_count <= pkt_count - ONE_P;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_avst_pkt_fifo.sv
// tb_avst_pkt_fifo: directed bench for the store-and-forward packet FIFO.
// A table of per-cycle vectors covers basic replay, sop-rewind drops,
// discarded sop-less beats and interleaved read/write; hand sequences cover
// filling the buffer, oversize packets and reset in mid-packet.
module tb_avst_pkt_fifo;

  logic        clk;
  logic        reset;
  logic        in_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [1:0]  in_empty;
  logic [0:0]  in_error;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
  logic [0:0]  out_error;
  logic [6:0]  pkt_count;
  logic        drop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          iv;
    int          isop;
    int          ieop;
    logic [31:0] idata;
    int          iemp;
    int          ierr;
    int          ordy;
    int          xrdy;
    int          xov;
    logic [31:0] xdata;
    int          xsop;
    int          xeop;
    int          xemp;
    int          xerr;
    int          xpkt;
    int          xdrop;
  } vec_t;

  vec_t vecs[$];

  avst_pkt_fifo #(
    .DATA_W(32), .EMPTY_W(2), .ERR_W(1), .DEPTH(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .in_empty(in_empty),
    .in_error(in_error),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_empty(out_empty),
    .out_error(out_error),
    .pkt_count(pkt_count),
    .drop(drop)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t row(input int iv, input int isop, input int ieop,
                               input logic [31:0] idata, input int iemp,
                               input int ierr, input int ordy, input int xrdy,
                               input int xov, input logic [31:0] xdata,
                               input int xsop, input int xeop, input int xemp,
                               input int xerr, input int xpkt, input int xdrop);
    vec_t v;
    v.iv = iv; v.isop = isop; v.ieop = ieop; v.idata = idata;
    v.iemp = iemp; v.ierr = ierr; v.ordy = ordy;
    v.xrdy = xrdy; v.xov = xov; v.xdata = xdata; v.xsop = xsop;
    v.xeop = xeop; v.xemp = xemp; v.xerr = xerr; v.xpkt = xpkt;
    v.xdrop = xdrop;
    return v;
  endfunction

  // Drive one cycle of inputs just after the falling edge, settle, return
  task automatic applyStimulus(input int iv, input int sop, input int eop,
                               input logic [31:0] d, input int emp,
                               input int err, input int ordy);
    @(negedge clk);
    in_valid         = 1'(iv);
    in_startofpacket = 1'(sop);
    in_endofpacket   = 1'(eop);
    in_data          = d;
    in_empty         = 2'(emp);
    in_error         = 1'(err);
    out_ready        = 1'(ordy);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v.iv, v.isop, v.ieop, v.idata, v.iemp, v.ierr, v.ordy);
    checkOutput($sformatf("row%0d in_ready", idx), 32'(in_ready), 32'(v.xrdy));
    checkOutput($sformatf("row%0d out_valid", idx), 32'(out_valid), 32'(v.xov));
    checkOutput($sformatf("row%0d pkt_count", idx), 32'(pkt_count), 32'(v.xpkt));
    checkOutput($sformatf("row%0d drop", idx), 32'(drop), 32'(v.xdrop));
    if (v.xov != 0) begin
      checkOutput($sformatf("row%0d out_data", idx), out_data, v.xdata);
      checkOutput($sformatf("row%0d out_sop", idx), 32'(out_startofpacket), 32'(v.xsop));
      checkOutput($sformatf("row%0d out_eop", idx), 32'(out_endofpacket), 32'(v.xeop));
      checkOutput($sformatf("row%0d out_empty", idx), 32'(out_empty), 32'(v.xemp));
      checkOutput($sformatf("row%0d out_error", idx), 32'(out_error), 32'(v.xerr));
    end
  endtask

  initial begin
    int drops;
    int dropAt;

    reset = 1'b1;
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    in_data = '0; in_empty = '0; in_error = '0; out_ready = 1'b0;

    // iv sop eop data emp err ordy | rdy ov data sop eop emp err pkt drop
    // Single 3-beat packet, empty=2 on eop, error on the middle beat
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,1,0,32'hA000_0000,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hA000_0001,0,1,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,1,32'hA000_0002,2,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hA000_0000,1,0,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hA000_0001,0,0,0,1,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hA000_0002,0,1,2,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    // Packet B0..B4 never ends; sop of C rewinds it and drop pulses once
    vecs.push_back(row(1,1,0,32'hB000_0000,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hB000_0001,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hB000_0002,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hB000_0003,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hB000_0004,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,1,0,32'hC000_0000,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hC000_0001,0,0,1,  1,0,32'h0,0,0,0,0,0,1));
    vecs.push_back(row(1,0,1,32'hC000_0002,1,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hC000_0000,1,0,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hC000_0001,0,0,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hC000_0002,0,1,1,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    // A beat without sop in IDLE is silently discarded
    vecs.push_back(row(1,0,1,32'hDDDD_DDDD,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,0,32'h0,0,0,0,0,0,0));
    // 4-beat packet P stored, then read with out_ready toggling; a single-beat
    // packet S commits on the same cycle P's eop leaves
    vecs.push_back(row(1,1,0,32'hE000_0000,0,0,0,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hE000_0001,0,0,0,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,0,32'hE000_0002,0,0,0,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(1,0,1,32'hE000_0003,0,0,0,  1,0,32'h0,0,0,0,0,0,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hE000_0000,1,0,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,0,  1,1,32'hE000_0001,0,0,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hE000_0001,0,0,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hE000_0002,0,0,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,0,  1,1,32'hE000_0003,0,1,0,0,1,0));
    vecs.push_back(row(1,1,1,32'hF000_0000,3,0,1,  1,1,32'hE000_0003,0,1,0,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,0,  1,1,32'hF000_0000,1,1,3,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,1,32'hF000_0000,1,1,3,0,1,0));
    vecs.push_back(row(0,0,0,32'h0,0,0,1,  1,0,32'h0,0,0,0,0,0,0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], i);
    end

    // Four 16-beat packets fill all 64 entries with the sink stalled
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, int'(i % 16 == 0), int'(i % 16 == 15), 32'h1000 + i, 0, 0, 0);
      checkOutput($sformatf("fill in_ready beat%0d", i), 32'(in_ready), 32'd1);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("fill full in_ready", 32'(in_ready), 32'd0);
    checkOutput("fill pkt_count", 32'(pkt_count), 32'd4);
    checkOutput("fill out_valid", 32'(out_valid), 32'd1);
    for (int j = 0; j < 64; j++) begin
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
      checkOutput($sformatf("drain valid %0d", j), 32'(out_valid), 32'd1);
      checkOutput($sformatf("drain data %0d", j), out_data, 32'h1000 + j);
      checkOutput($sformatf("drain sop %0d", j), 32'(out_startofpacket), 32'(j % 16 == 0));
      checkOutput($sformatf("drain eop %0d", j), 32'(out_endofpacket), 32'(j % 16 == 15));
      if (j == 0) checkOutput("drain in_ready before read", 32'(in_ready), 32'd0);
      if (j == 1) checkOutput("drain in_ready after read", 32'(in_ready), 32'd1);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("drain done out_valid", 32'(out_valid), 32'd0);
    checkOutput("drain done pkt_count", 32'(pkt_count), 32'd0);

    // 70-beat packet cannot fit: one drop after the 64th beat, nothing out
    drops = 0;
    dropAt = -1;
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1, int'(i == 0), int'(i == 69), 32'h2000 + i, 0, 0, 1);
      checkOutput($sformatf("ovf in_ready %0d", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("ovf out_valid %0d", i), 32'(out_valid), 32'd0);
      if (drop) begin
        drops++;
        dropAt = i;
      end
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    if (drop) drops++;
    checkOutput("ovf drop count", 32'(drops), 32'd1);
    checkOutput("ovf drop cycle", 32'(dropAt), 32'd64);
    checkOutput("ovf after out_valid", 32'(out_valid), 32'd0);
    checkOutput("ovf after pkt_count", 32'(pkt_count), 32'd0);
    applyStimulus(1, 1, 0, 32'h2100, 0, 0, 1);
    applyStimulus(1, 0, 1, 32'h2101, 1, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("post-ovf beat0 valid", 32'(out_valid), 32'd1);
    checkOutput("post-ovf beat0 data", out_data, 32'h2100);
    checkOutput("post-ovf beat0 sop", 32'(out_startofpacket), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("post-ovf beat1 data", out_data, 32'h2101);
    checkOutput("post-ovf beat1 eop", 32'(out_endofpacket), 32'd1);
    checkOutput("post-ovf beat1 empty", 32'(out_empty), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("post-ovf out_valid", 32'(out_valid), 32'd0);

    // Reset with a stored 6-beat packet plus 4 partial beats
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, int'(i == 0), int'(i == 5), 32'h3000 + i, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, int'(i == 0), 0, 32'h3100 + i, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("prereset out_valid", 32'(out_valid), 32'd1);
    checkOutput("prereset pkt_count", 32'(pkt_count), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset pkt_count", 32'(pkt_count), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset drop", 32'(drop), 32'd0);
    applyStimulus(1, 1, 0, 32'h3200, 0, 0, 1);
    applyStimulus(1, 0, 0, 32'h3201, 0, 0, 1);
    applyStimulus(1, 0, 1, 32'h3202, 3, 1, 1);
    checkOutput("fresh no early valid", 32'(out_valid), 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("fresh beat0 data", out_data, 32'h3200);
    checkOutput("fresh beat0 sop", 32'(out_startofpacket), 32'd1);
    checkOutput("fresh pkt_count", 32'(pkt_count), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("fresh beat1 data", out_data, 32'h3201);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("fresh beat2 data", out_data, 32'h3202);
    checkOutput("fresh beat2 eop", 32'(out_endofpacket), 32'd1);
    checkOutput("fresh beat2 empty", 32'(out_empty), 32'd3);
    checkOutput("fresh beat2 error", 32'(out_error), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    checkOutput("fresh done out_valid", 32'(out_valid), 32'd0);
    checkOutput("fresh done pkt_count", 32'(pkt_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avst_pkt_fifo.md
# avst_pkt_fifo

Store-and-forward packet FIFO placed between an Avalon-ST source and the downstream Avalon-ST sink in the copy-memory packet path. It accepts beats on an Avalon-ST sink port and buffers each packet until its endofpacket beat arrives. Only then does it replay the packet on an Avalon-ST source port, so downstream never sees a partial packet. Malformed and oversize packets are discarded whole.

## Interface
- DATA_W, 32, data bus width (BITS_PER_SYMBOL × SYMBOL_PER_BEAT)
- EMPTY_W, 2, width of empty (log2 SYMBOL_PER_BEAT)
- ERR_W, 1, width of error
- DEPTH, 64, beat storage, power of 2, ≥ 4
- READY_LATENCY is fixed at 0 on both ports; no channel signal
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  sink may accept beat
- in_valid  in  1  input beat valid
- in_data  in  DATA_W  input data
- in_startofpacket  in  1  first beat of packet
- in_endofpacket  in  1  last beat of packet
- in_empty  in  EMPTY_W  unused symbols on eop beat
- in_error  in  ERR_W  error bits, stored per beat
- out_ready  in  1  downstream accepts
- out_valid  out  1  output beat valid
- out_data, out_startofpacket, out_endofpacket, out_empty, out_error  out  as input  replayed beat
- pkt_count  out  log2(DEPTH)+1  complete packets stored
- drop  out  1  one-cycle pulse per discarded packet

## Operation
- Storage: DEPTH entries of {data, sop, eop, empty, error}. Pointers are log2(DEPTH)+1 bits wide, with an extra wrap bit.
- Three pointers: wr_ptr (next write), commit_ptr (entry after last stored eop), rd_ptr.
- full = (wr_ptr − rd_ptr) == DEPTH. out_valid = (rd_ptr ≠ commit_ptr).
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Write FSM states: IDLE, PKT, DROP.
  - IDLE: a beat with sop is written and moves the FSM to PKT. If the beat also has eop, it is committed and the FSM stays in IDLE. A beat without sop is discarded silently, with no drop pulse.
  - PKT: beats are written. An eop beat sets commit_ptr = wr_ptr+1 and returns to IDLE. A sop beat while in PKT rewinds wr_ptr to commit_ptr, pulses drop, and is written as the start of the new packet; the FSM stays in PKT.
  - Overflow: full, pkt_count == 0 and state PKT means the packet cannot fit. The block rewinds wr_ptr to commit_ptr, pulses drop, and enters DROP.
  - DROP: in_ready = 1. All beats are discarded until an eop beat, then the FSM returns to IDLE. A sop beat while in DROP is discarded like any other beat.
- in_ready = !full | (state == DROP). If full while a complete packet is stored, the block backpressures and does not drop.
- pkt_count increments on each commit and decrements on each output transfer with eop. Both on the same cycle leaves it unchanged.
- Output fields are an asynchronous read of entry rd_ptr. Simultaneous read and write to different entries are both honoured.
- Reset: all pointers = 0, state IDLE, pkt_count = 0, drop = 0, in_ready = 1, out_valid = 0. A packet partially received at reset is lost, with no drop pulse.

## Timing
- Commit latency: an eop accepted in cycle N gives out_valid = 1 in cycle N+1.
- Read: out_* are valid in the same cycle that rd_ptr points at a committed entry. rd_ptr advances on the clock edge of each output transfer.
- Back-to-back beats run at full rate, one per cycle on each port.
- in_ready deasserts in the cycle after the DEPTH-th uncommitted write. It reasserts in the cycle after an output transfer frees an entry.
- drop asserts in the cycle after the triggering beat (rewinding sop, or the beat that fills the buffer). It stays high for exactly 1 cycle.
- out_valid is held, with stable fields, while out_ready = 0.

## Test plan
- Single 3-beat packet (sop…eop, empty=2), out_ready=1 → out_valid rises in the cycle after eop. Three beats replay unchanged with empty=2, and pkt_count goes 0→1→0.
- Four 16-beat packets streamed in with out_ready=0 → pkt_count=4, full, in_ready=0. Raising out_ready → 64 beats out in order, with in_ready high again 1 cycle after the first read.
- 70-beat packet into empty FIFO, DEPTH=64 → one drop pulse, state DROP, nothing output. The next 2-beat packet is output intact.
- Packet A of 5 beats without eop, then sop of packet B of 3 beats → drop pulses once, and only B is output.
- Single-beat packet (sop=eop=1) written while another packet is being read, out_ready toggling → order is preserved and pkt_count is correct on the simultaneous inc/dec cycle.
- Reset asserted mid-packet with 10 stored beats → the next cycle shows out_valid=0, pkt_count=0, in_ready=1. A fresh packet then passes normally.
